botao_debounce: RTL

Two-channel push-button conditioner that sits directly upstream of the Botao2 position block. It takes raw, asynchronous, bouncing button lines and synchronises and debounces them. It drives the clean level signals SinalBotao1/SinalBotao2 that Botao2 consumes. It also emits one-cycle press pulses for any edge-driven logic downstream.

---
 rtl/botao_debounce_if.sv | 11 +
 rtl/botao_debounce.sv | 84 ++++++++
 2 files changed

// File: rtl/botao_debounce_if.sv
// botao_debounce_if: raw button lines in, debounced levels and press pulses out
interface botao_debounce_if;
  logic BotaoBruto1;
  logic BotaoBruto2;
  logic SinalBotao1;
  logic SinalBotao2;
  logic Pulso1;
  logic Pulso2;
  modport master (output BotaoBruto1, BotaoBruto2, input SinalBotao1, SinalBotao2, Pulso1, Pulso2);
  modport slave (input BotaoBruto1, BotaoBruto2, output SinalBotao1, SinalBotao2, Pulso1, Pulso2);
endinterface

// File: rtl/botao_debounce.sv
// botao_debounce: two-channel button synchroniser/debouncer with press pulses.
// Define BOTAO_EXCLUSAO_EN to blank both levels while both buttons are held.
module botao_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20
) (
  input logic clk,
  input logic rst_n,
  botao_debounce_if.slave bus
);
  typedef enum logic [1:0] {SOLTO, CONF_PRESS, PRESSIONADO, CONF_SOLTA} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] raw, sync1_q, sync2_q, lvl, pulse;
  assign raw = {bus.BotaoBruto2, bus.BotaoBruto1};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end
  for (genvar c = 0; c < 2; c++) begin : g_ch
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic pulse_q, acc_d, lvl_c;
    logic s;
    assign s = sync2_q[c];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= SOLTO;
        cnt_q <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        pulse_q <= acc_d;
      end
    end
    // counter clears on every state change, so it never carries across a bounce
    always_comb begin
      state_d = state_q;
      cnt_d = '0;
      case (state_q)
        SOLTO: state_d = s ? CONF_PRESS : SOLTO;
        CONF_PRESS:
          if (!s) state_d = SOLTO;
          else if (cnt_q == LAST) state_d = PRESSIONADO;
          else cnt_d = cnt_q + 1'b1;
        PRESSIONADO: state_d = s ? PRESSIONADO : CONF_SOLTA;
        CONF_SOLTA:
          if (s) state_d = PRESSIONADO;
          else if (cnt_q == LAST) state_d = SOLTO;
          else cnt_d = cnt_q + 1'b1;
        default: state_d = SOLTO;
      endcase
    end
    always_comb begin
      lvl_c = (state_q == PRESSIONADO) || (state_q == CONF_SOLTA);
      acc_d = (state_q == CONF_PRESS) && (state_d == PRESSIONADO);
    end
    assign lvl[c] = lvl_c;
    assign pulse[c] = pulse_q;
  end
`ifdef BOTAO_EXCLUSAO_EN
  logic lock_q, both;
  assign both = &lvl;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else lock_q <= both;
  end
  // lock_q keeps the blanking one cycle past the end of the overlap
  assign bus.SinalBotao1 = lvl[0] & ~both & ~lock_q;
  assign bus.SinalBotao2 = lvl[1] & ~both & ~lock_q;
  assign bus.Pulso1 = pulse[0] & ~both & ~lock_q;
  assign bus.Pulso2 = pulse[1] & ~both & ~lock_q;
`else
  assign bus.SinalBotao1 = lvl[0];
  assign bus.SinalBotao2 = lvl[1];
  assign bus.Pulso1 = pulse[0];
  assign bus.Pulso2 = pulse[1];
`endif
endmodule
